amo_unit: RTL

Multicycle atomic-memory sequencer for the rv32ima core. It executes the A-extension read-modify-write instructions (LR.W, SC.W, AMO*.W) and sits directly downstream of the control unit's execute decode. It drives the shared `alu` with the loaded word and rs2, captures the ALU result, and writes it back through the data-memory port. It returns the original memory word, or the SC status, as the rd value.

---
 rtl/amo_unit_pkg.sv | 33 +++
 rtl/amo_unit.sv | 128 ++++++++++++
 2 files changed

// File: rtl/amo_unit_pkg.sv
// amo_unit_pkg: ALU control codes, AMO funct5 encodings and sequencer state encodings
package amo_unit_pkg;
  localparam int ALU_CTRL_WIDTH = 4;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_ADD_ADDI = 4'd0;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_XOR_XORI = 4'd4;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_OR_ORI   = 4'd6;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_AND_ANDI = 4'd7;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_LUI      = 4'd10;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_MIN      = 4'd11;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_MAX      = 4'd12;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_MINU     = 4'd13;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_MAXU     = 4'd14;
  localparam logic [4:0] AMO_ADD  = 5'b00000;
  localparam logic [4:0] AMO_SWAP = 5'b00001;
  localparam logic [4:0] AMO_LR   = 5'b00010;
  localparam logic [4:0] AMO_SC   = 5'b00011;
  localparam logic [4:0] AMO_XOR  = 5'b00100;
  localparam logic [4:0] AMO_OR   = 5'b01000;
  localparam logic [4:0] AMO_AND  = 5'b01100;
  localparam logic [4:0] AMO_MIN  = 5'b10000;
  localparam logic [4:0] AMO_MAX  = 5'b10100;
  localparam logic [4:0] AMO_MINU = 5'b11000;
  localparam logic [4:0] AMO_MAXU = 5'b11100;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_CALC  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  function automatic logic amo_legal(input logic [4:0] f);
    return f inside {AMO_ADD, AMO_SWAP, AMO_LR, AMO_SC, AMO_XOR, AMO_OR, AMO_AND,
                     AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU};
  endfunction
endpackage

// File: rtl/amo_unit.sv
// amo_unit: multicycle LR/SC/AMO read-modify-write sequencer driving the shared ALU and data memory
module amo_unit import amo_unit_pkg::*; #(
  parameter bit LR_SC_ENABLE = 1'b1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic [4:0]                funct5,
  input  logic [31:0]               addr,
  input  logic [31:0]               rs2,
  input  logic                      invalidate,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [31:0]               rd_data,
  output logic                      mem_valid,
  output logic                      mem_we,
  output logic [31:0]               mem_addr,
  output logic [31:0]               mem_wdata,
  output logic [3:0]                mem_wmask,
  input  logic                      mem_ready,
  input  logic [31:0]               mem_rdata,
  output logic [31:0]               alu_a,
  output logic [31:0]               alu_b,
  output logic [ALU_CTRL_WIDTH-1:0] alu_ctrl,
  input  logic [31:0]               alu_result
);
  logic [2:0]  state;
  logic [4:0]  f5_q;
  logic [31:0] addr_q, rs2_q, old_q, new_q, res_addr;
  logic        res_valid, xfer, legal, sc_ok, calc;
  function automatic logic [ALU_CTRL_WIDTH-1:0] alu_map(input logic [4:0] f);
    case (f)
      AMO_SWAP: return ALU_CTRL_LUI;
      AMO_XOR:  return ALU_CTRL_XOR_XORI;
      AMO_OR:   return ALU_CTRL_OR_ORI;
      AMO_AND:  return ALU_CTRL_AND_ANDI;
      AMO_MIN:  return ALU_CTRL_MIN;
      AMO_MAX:  return ALU_CTRL_MAX;
      AMO_MINU: return ALU_CTRL_MINU;
      AMO_MAXU: return ALU_CTRL_MAXU;
      default:  return ALU_CTRL_ADD_ADDI;
    endcase
  endfunction
  assign xfer      = mem_valid && mem_ready;
  assign legal     = amo_legal(funct5) && addr[1:0] == 2'b00;
  assign sc_ok     = LR_SC_ENABLE && res_valid && res_addr == addr && !invalidate;
  assign calc      = state == S_CALC;
  assign busy      = state != S_IDLE;
  assign done      = state == S_DONE;
  assign mem_we    = state == S_WRITE;
  assign mem_addr  = addr_q;
  assign mem_wdata = mem_we ? new_q : '0;
  assign mem_wmask = {4{mem_we}};
  assign alu_a     = calc ? old_q : '0;
  assign alu_b     = calc ? rs2_q : '0;
  assign alu_ctrl  = calc ? alu_map(f5_q) : ALU_CTRL_ADD_ADDI;
  // sequencer: decode/latch in IDLE, memory handshakes in READ/WRITE, ALU capture in CALC
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      f5_q      <= '0;
      addr_q    <= '0;
      rs2_q     <= '0;
      old_q     <= '0;
      new_q     <= '0;
      mem_valid <= 1'b0;
      err       <= 1'b0;
      rd_data   <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          addr_q <= addr;
          rs2_q  <= rs2;
          f5_q   <= funct5;
          if (!legal) begin
            state   <= S_DONE;
            err     <= 1'b1;
            rd_data <= '0;
          end else if (funct5 == AMO_SC) begin
            state     <= sc_ok ? S_WRITE : S_DONE;
            mem_valid <= sc_ok;
            new_q     <= rs2;
            rd_data   <= {31'd0, !sc_ok};
          end else begin
            state     <= S_READ;
            mem_valid <= 1'b1;
          end
        end
        S_READ: if (xfer) begin
          mem_valid <= 1'b0;
          old_q     <= mem_rdata;
          rd_data   <= mem_rdata;
          state     <= f5_q == AMO_LR ? S_DONE : S_CALC;
        end
        S_CALC: begin
          new_q     <= alu_result;
          mem_valid <= 1'b1;
          state     <= S_WRITE;
        end
        S_WRITE: if (xfer) begin
          mem_valid <= 1'b0;
          state     <= S_DONE;
        end
        default: begin
          state   <= S_IDLE;
          err     <= 1'b0;
          rd_data <= '0;
        end
      endcase
    end
  end
  // reservation: cleared by invalidate, any SC, or an AMO store to it; an LR completing on the same edge wins
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      res_valid <= 1'b0;
      res_addr  <= '0;
    end else begin
      if (invalidate || (state == S_IDLE && start && legal && funct5 == AMO_SC) ||
          (state == S_WRITE && xfer && f5_q != AMO_SC && addr_q == res_addr))
        res_valid <= 1'b0;
      if (LR_SC_ENABLE && state == S_READ && xfer && f5_q == AMO_LR) begin
        res_valid <= 1'b1;
        res_addr  <= addr_q;
      end
    end
  end
endmodule
